// File: rtl/dmem_store_buffer_ctrl.sv
// Store-buffer controller that owns the data-memory port: stores are posted to a FIFO and retired in idle cycles.
// Define DMEM_ALIGN_CHK_EN to flag misaligned halfword/word accesses instead of performing them.
module dmem_store_buffer_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_se,
    input  logic [31:0]            req_data,
    input  logic                   drain_req,
    output logic                   stall,
    output logic [31:0]            load_data,
    output logic                   misalign,
    output logic [$clog2(DEPTH):0] sb_count,
    output logic                   sb_empty,
    output logic [ADDR_W-1:0]      dm_a,
    output logic [31:0]            dm_di,
    output logic [1:0]             dm_size,
    output logic                   dm_rw,
    output logic                   dm_e,
    output logic                   dm_se,
    input  logic [31:0]            dm_do
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [31:0]       data_q [DEPTH];

    logic hazard, misalChk, badReq, doDrain, doEnq, bufEmpty, bufFull;

    function automatic logic [ADDR_W-1:0] span(input logic [1:0] size);
        case (size)
            2'b00:   span = ADDR_W'(1);
            2'b01:   span = ADDR_W'(2);
            default: span = ADDR_W'(4);
        endcase
    endfunction

`ifdef DMEM_ALIGN_CHK_EN
    assign misalChk = req_valid & (((req_size == 2'b01) & req_addr[0]) |
                                   ((req_size == 2'b10) & (req_addr[1:0] != 2'b00)));
`else
    assign misalChk = 1'b0;
`endif

    assign badReq   = (req_size == 2'b11) | misalChk;
    assign bufEmpty = (count_q == '0);
    assign bufFull  = (count_q == CW'(DEPTH));

    // Byte ranges overlap iff the modular distance from one start to the other is below that side's length.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) &&
                (((req_addr - addr_q[head_q + PW'(k)]) < span(size_q[head_q + PW'(k)])) ||
                 ((addr_q[head_q + PW'(k)] - req_addr) < span(req_size))))
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        doDrain   = 1'b0;
        doEnq     = 1'b0;
        stall     = 1'b0;
        load_data = 32'd0;
        dm_a      = '0;
        dm_di     = 32'd0;
        dm_size   = 2'b10;
        dm_rw     = 1'b0;
        dm_e      = 1'b0;
        dm_se     = 1'b0;
        if (state_q == RUN) begin
            if (drain_req)
                state_d = FLUSH;
            if (req_valid && !badReq) begin
                if (!req_rw) begin
                    if (hazard) begin
                        stall   = 1'b1;
                        doDrain = 1'b1;
                    end else begin
                        dm_a      = req_addr;
                        dm_size   = req_size;
                        dm_se     = req_se;
                        load_data = dm_do;
                    end
                end else if (!bufFull) begin
                    doEnq   = 1'b1;
                    doDrain = !bufEmpty;
                end else begin
                    stall   = 1'b1;
                    doDrain = 1'b1;
                end
            end else begin
                doDrain = !bufEmpty;
            end
        end else begin
            stall   = req_valid;
            doDrain = !bufEmpty;
            if (!drain_req && bufEmpty)
                state_d = RUN;
        end
        if (doDrain) begin
            dm_a    = addr_q[head_q];
            dm_di   = data_q[head_q];
            dm_size = size_q[head_q];
            dm_rw   = 1'b1;
            dm_e    = 1'b1;
        end
        // Reset wins over everything so a drain write in flight during reset never reaches memory.
        if (reset) begin
            stall     = 1'b0;
            load_data = 32'd0;
            doDrain   = 1'b0;
            doEnq     = 1'b0;
            dm_a      = '0;
            dm_di     = 32'd0;
            dm_size   = 2'b10;
            dm_rw     = 1'b0;
            dm_e      = 1'b0;
            dm_se     = 1'b0;
        end
    end

    assign head_d  = head_q + PW'(doDrain);
    assign tail_d  = tail_q + PW'(doEnq);
    assign count_d = count_q + CW'(doEnq) - CW'(doDrain);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doEnq) begin
            addr_q[tail_q] <= req_addr;
            size_q[tail_q] <= req_size;
            data_q[tail_q] <= req_data;
        end
    end

    assign misalign = misalChk & ~reset;
    assign sb_count = reset ? '0 : count_q;
    assign sb_empty = (sb_count == '0);
endmodule

// File: tb/tb_dmem_store_buffer_ctrl.sv
// Bench for dmem_store_buffer_ctrl: a byte-array data memory, a queue-based reference model and directed literal checks.
// Honours DMEM_ALIGN_CHK_EN the same way the design does.
module tb_dmem_store_buffer_ctrl;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 9;
    localparam int MEMSZ  = 512;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_rw, req_se, drain_req;
    logic [8:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        stall, misalign, sb_empty, dm_rw, dm_e, dm_se;
    logic [31:0] load_data, dm_di, dm_do;
    logic [2:0]  sb_count;
    logic [8:0]  dm_a;
    logic [1:0]  dm_size;

    dmem_store_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_size(req_size), .req_se(req_se), .req_data(req_data),
        .drain_req(drain_req), .stall(stall), .load_data(load_data), .misalign(misalign),
        .sb_count(sb_count), .sb_empty(sb_empty), .dm_a(dm_a), .dm_di(dm_di),
        .dm_size(dm_size), .dm_rw(dm_rw), .dm_e(dm_e), .dm_se(dm_se), .dm_do(dm_do)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 73 + 29) ^ (i >>> 2));
    endfunction

    function automatic int nBytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Data memory: combinational little-endian read, write on the clock edge when E and RW are high.
    logic [7:0] mem [MEMSZ];
    logic [7:0] b0, b1, b2, b3;
    bit         initDone;

    always_comb begin
        b0 = mem[dm_a];
        b1 = mem[dm_a + 9'd1];
        b2 = mem[dm_a + 9'd2];
        b3 = mem[dm_a + 9'd3];
        case (dm_size)
            2'b00:   dm_do = {{24{dm_se & b0[7]}}, b0};
            2'b01:   dm_do = {{16{dm_se & b1[7]}}, b1, b0};
            default: dm_do = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (!initDone) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] <= initByte(i);
            initDone <= 1'b1;
        end else if (dm_e && dm_rw) begin
            for (int k = 0; k < nBytes(dm_size); k++)
                mem[9'(int'(dm_a) + k)] <= dm_di[8*k +: 8];
        end
    end

    // Reference model: architectural memory of retired stores plus a queue of posted stores.
    typedef struct {
        logic [8:0]  a;
        logic [1:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  mm [MEMSZ];
    bit          mmInit, flushM, nextFlush, drainM, enqM, misM, badM;
    int          cnt, checks, failures, litSeq, litSeen;
    logic        eStall, eMis, eE, eRw, eSe;
    logic [31:0] eLoad, eDi;
    logic [8:0]  eA;
    logic [1:0]  eSize;
    ent_t        newEnt;
    logic [7:0]  litMask;
    logic [31:0] litVal [8];

    function automatic bit pendingOverlap(input logic [8:0] la, input int ln);
        foreach (q[i])
            for (int j = 0; j < ln; j++)
                for (int k = 0; k < nBytes(q[i].s); k++)
                    if (((int'(la) + j) % MEMSZ) == ((int'(q[i].a) + k) % MEMSZ)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [8:0] a, input logic [1:0] s, input logic se);
        logic [31:0] w = 32'd0;
        int n = nBytes(s);
        for (int k = 0; k < n; k++) w[8*k +: 8] = mm[(int'(a) + k) % MEMSZ];
        if (se && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8 * n));
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] dutSig(input int i);
        case (i)
            0: return {31'd0, stall};
            1: return load_data;
            2: return {31'd0, misalign};
            3: return {29'd0, sb_count};
            4: return {31'd0, sb_empty};
            5: return {31'd0, dm_e};
            6: return {23'd0, dm_a};
            default: return dm_di;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!mmInit) begin
            for (int i = 0; i < MEMSZ; i++) mm[i] = initByte(i);
            mmInit = 1'b1;
        end
        if (litSeq != litSeen) begin
            litSeen = litSeq;
            for (int i = 0; i < 8; i++)
                if (litMask[i]) checkOutput($sformatf("literal_%0d", i), dutSig(i), litVal[i]);
        end
        cnt = q.size();
        {eStall, eMis, eE, eRw, eSe, drainM, enqM, misM} = '0;
        eLoad = 32'd0; eDi = 32'd0; eA = 9'd0; eSize = 2'b10;
`ifdef DMEM_ALIGN_CHK_EN
        misM = req_valid && ((req_size == 2'b01 && req_addr[0]) ||
                             (req_size == 2'b10 && req_addr[1:0] != 2'b00));
`endif
        badM = (req_size == 2'b11) || misM;
        if (reset) begin
            checkOutput("rst_stall", {31'd0, stall}, 32'd0);
            checkOutput("rst_load_data", load_data, 32'd0);
            checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
            checkOutput("rst_sb_count", {29'd0, sb_count}, 32'd0);
            checkOutput("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
            checkOutput("rst_dm_e", {31'd0, dm_e}, 32'd0);
            checkOutput("rst_dm_rw", {31'd0, dm_rw}, 32'd0);
            q.delete();
            flushM = 1'b0;
        end else begin
            eMis = misM;
            if (!flushM) begin
                if (req_valid && !badM) begin
                    if (!req_rw) begin
                        if (pendingOverlap(req_addr, nBytes(req_size))) begin
                            eStall = 1'b1; drainM = 1'b1;
                        end else begin
                            eLoad = modelRead(req_addr, req_size, req_se);
                            eA = req_addr; eSize = req_size; eSe = req_se;
                        end
                    end else if (cnt < DEPTH) begin
                        enqM = 1'b1; drainM = (cnt > 0);
                    end else begin
                        eStall = 1'b1; drainM = 1'b1;
                    end
                end else begin
                    drainM = (cnt > 0);
                end
                nextFlush = drain_req;
            end else begin
                eStall = req_valid;
                drainM = (cnt > 0);
                nextFlush = drain_req || (cnt != 0);
            end
            if (drainM) begin
                eE = 1'b1; eRw = 1'b1; eA = q[0].a; eSize = q[0].s; eDi = q[0].d;
            end
            checkOutput("stall", {31'd0, stall}, {31'd0, eStall});
            checkOutput("load_data", load_data, eLoad);
            checkOutput("misalign", {31'd0, misalign}, {31'd0, eMis});
            checkOutput("sb_count", {29'd0, sb_count}, cnt);
            checkOutput("sb_empty", {31'd0, sb_empty}, {31'd0, cnt == 0});
            checkOutput("dm_e", {31'd0, dm_e}, {31'd0, eE});
            checkOutput("dm_rw", {31'd0, dm_rw}, {31'd0, eRw});
            checkOutput("dm_a", {23'd0, dm_a}, {23'd0, eA});
            checkOutput("dm_di", dm_di, eDi);
            checkOutput("dm_size", {30'd0, dm_size}, {30'd0, eSize});
            checkOutput("dm_se", {31'd0, dm_se}, {31'd0, eSe});
            if (drainM) begin
                for (int k = 0; k < nBytes(q[0].s); k++)
                    mm[(int'(q[0].a) + k) % MEMSZ] = q[0].d[8*k +: 8];
                q.delete(0);
            end
            if (enqM) begin
                newEnt.a = req_addr; newEnt.s = req_size; newEnt.d = req_data;
                q.push_back(newEnt);
            end
            flushM = nextFlush;
        end
    end

    // Literal expectations are posted here and checked by the compare process at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic rw, input logic [8:0] a,
                                 input logic [1:0] s, input logic se, input logic [31:0] d,
                                 input logic dr);
        @(posedge clk); #1;
        reset = rst; req_valid = v; req_rw = rw; req_addr = a; req_size = s;
        req_se = se; req_data = d; drain_req = dr;
        litMask = 8'd0;
        litSeq++;
    endtask

    task automatic expectLit(input int idx, input logic [31:0] v);
        litMask[idx] = 1'b1;
        litVal[idx] = v;
    endtask

    bit         hold;
    int         drainLeft, r;
    logic [8:0] base;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 9'd0; req_size = 2'b10;
        req_se = 1'b0; req_data = 32'd0; drain_req = 1'b0; litMask = 8'd0;
        repeat (3) @(posedge clk);

        applyStimulus(0, 1, 1, 9'h010, 2'b10, 0, 32'hDEADBEEF, 0);
        expectLit(0, 0); expectLit(3, 0); expectLit(5, 0);
        applyStimulus(0, 0, 0, 9'h000, 2'b10, 0, 32'd0, 0);
        expectLit(3, 1); expectLit(5, 1); expectLit(6, 32'h010); expectLit(7, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 9'h010, 2'b10, 0, 32'd0, 0);
        expectLit(0, 0); expectLit(1, 32'hDEADBEEF); expectLit(4, 1);

        applyStimulus(0, 1, 1, 9'h020, 2'b00, 0, 32'h80, 0);
        expectLit(0, 0);
        applyStimulus(0, 1, 0, 9'h020, 2'b00, 1, 32'd0, 0);
        expectLit(0, 1); expectLit(1, 0); expectLit(5, 1);
        applyStimulus(0, 1, 0, 9'h020, 2'b00, 1, 32'd0, 0);
        expectLit(0, 0); expectLit(1, 32'hFFFFFF80);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 9'(9'h040 + 4 * i), 2'b10, 0, 32'h1111_1111 * (i + 1), 0);
            expectLit(0, 0); expectLit(3, (i == 0) ? 0 : 1);
        end
        applyStimulus(0, 0, 0, 9'h000, 2'b10, 0, 32'd0, 0);
        expectLit(3, 1); expectLit(6, 32'h050); expectLit(7, 32'h5555_5555);

        applyStimulus(0, 1, 1, 9'h1FF, 2'b01, 0, 32'h0000A55A, 0);
        expectLit(0, 0); expectLit(3, 0);
        applyStimulus(0, 1, 0, 9'h000, 2'b00, 0, 32'd0, 0);
        expectLit(0, 1); expectLit(6, 32'h1FF);
        applyStimulus(0, 1, 0, 9'h000, 2'b00, 0, 32'd0, 0);
        expectLit(0, 0); expectLit(1, 32'h000000A5);
        applyStimulus(0, 1, 0, 9'h1FF, 2'b00, 0, 32'd0, 0);
        expectLit(1, 32'h0000005A);

        applyStimulus(0, 1, 1, 9'h080, 2'b10, 0, 32'h12345678, 0);
        applyStimulus(0, 1, 0, 9'h100, 2'b10, 0, 32'd0, 1);
        expectLit(0, 0); expectLit(3, 1);
        applyStimulus(0, 1, 0, 9'h100, 2'b10, 0, 32'd0, 1);
        expectLit(0, 1); expectLit(5, 1); expectLit(6, 32'h080);
        applyStimulus(0, 1, 0, 9'h100, 2'b10, 0, 32'd0, 1);
        expectLit(0, 1); expectLit(4, 1);
        applyStimulus(0, 1, 0, 9'h100, 2'b10, 0, 32'd0, 0);
        expectLit(0, 1);
        applyStimulus(0, 1, 0, 9'h100, 2'b10, 0, 32'd0, 0);
        expectLit(0, 0);

        applyStimulus(0, 1, 0, 9'h002, 2'b10, 0, 32'd0, 0);
        expectLit(0, 0); expectLit(3, 0);
`ifdef DMEM_ALIGN_CHK_EN
        expectLit(2, 1); expectLit(1, 0);
`else
        expectLit(2, 0);
`endif

        applyStimulus(0, 1, 1, 9'h0C0, 2'b10, 0, 32'hCAFEF00D, 0);
        applyStimulus(1, 0, 0, 9'h000, 2'b10, 0, 32'd0, 0);
        expectLit(5, 0); expectLit(3, 0); expectLit(0, 0);
        applyStimulus(0, 1, 0, 9'h0C0, 2'b10, 0, 32'd0, 0);
        expectLit(0, 0);
        expectLit(1, {initByte(9'h0C3), initByte(9'h0C2), initByte(9'h0C1), initByte(9'h0C0)});

        drainLeft = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hold = stall;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            if (drainLeft > 0) drainLeft--;
            else if ($urandom_range(0, 39) == 0) drainLeft = $urandom_range(1, 8);
            drain_req = (drainLeft > 0);
            if (!hold || reset) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_rw = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 7);
                base = (r < 2) ? 9'h1F8 : (r == 7) ? 9'($urandom) : 9'h040;
                req_addr = base + 9'($urandom_range(0, 15));
                r = $urandom_range(0, 15);
                req_size = (r == 0) ? 2'b11 : 2'(r % 3);
                req_se = 1'($urandom_range(0, 1));
                req_data = $urandom;
            end
        end

        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; drain_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
